// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the UART boot loader.
package boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, REGION, LEN_LO, LEN_HI, DATA, CSUM, ERR, DONE} ldr_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit qualification at half bit, mid-bit sampling.
module uart_rx_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 128_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic        rx_m, rx_s, rx_d;
  logic [7:0]  shift_p0;

  assign byte_out = shift_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_d       <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + CW'(1);
        end
        RX_DATA: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else cnt <= cnt + CW'(1);
        end
        default: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) byte_valid <= 1'b1;
            else frame_err <= 1'b1;
          end else cnt <= cnt + CW'(1);
        end
      endcase
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (state == RX_DATA && cnt == CW'(CPB - 1)) shift_p0 <= {rx_s, shift_p0[7:1]};
  end
endmodule

// File: rtl/uart_boot_loader.sv
// Framed multi-region UART image loader: SYNC, REGION, LEN, little-endian words, XOR checksum.
module uart_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 128_000,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 14,
  parameter int NUM_REGIONS = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rx,
  output logic                                  wr_en,
  output logic [clog2_min1(NUM_REGIONS)-1:0]    wr_region,
  output logic [ADDR_W-1:0]                     addr_out,
  output logic [DATA_W-1:0]                     data_out,
  output logic                                  busy,
  output logic [NUM_REGIONS-1:0]                region_loaded,
  output logic                                  done,
  output logic                                  error
);
  localparam int BPW = DATA_W / 8;
  localparam int RW  = clog2_min1(NUM_REGIONS);
  localparam int BW  = clog2_min1(BPW);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] DEPTH_L = 17'(2 ** ADDR_W);
  localparam logic [7:0]  NREG_B  = 8'(NUM_REGIONS);

  logic [7:0] byte_out;
  logic       byte_valid, frame_err;

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  ldr_state_t         state;
  logic [RW-1:0]      region;
  logic [ADDR_W-1:0]  addr;
  logic [BW-1:0]      byte_idx;
  logic [TW-1:0]      tmo;
  logic [7:0]         len_lo_p0, csum_p0;
  logic [15:0]        len_p0;
  logic [DATA_W-1:0]  word_p0;

  logic [DATA_W+7:0]      word_cat;
  logic [DATA_W-1:0]      word_nxt;
  logic [15:0]            len_nxt;
  logic [NUM_REGIONS-1:0] mask_set;
  logic                   in_frame, last_byte, last_word;

  assign word_cat  = {byte_out, word_p0};
  assign word_nxt  = word_cat[DATA_W+7:8];
  assign len_nxt   = {byte_out, len_lo_p0};
  assign mask_set  = region_loaded | (NUM_REGIONS'(1) << region);
  assign in_frame  = state inside {REGION, LEN_LO, LEN_HI, DATA, CSUM};
  assign last_byte = (byte_idx == BW'(BPW - 1));
  assign last_word = ((17'(addr) + 17'd1) == {1'b0, len_p0});
  assign busy      = in_frame || (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      region        <= '0;
      addr          <= '0;
      byte_idx      <= '0;
      tmo           <= '0;
      wr_en         <= 1'b0;
      wr_region     <= '0;
      addr_out      <= '0;
      data_out      <= '0;
      region_loaded <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      tmo   <= (byte_valid || !in_frame) ? '0 : tmo + TW'(1);
      case (state)
        IDLE: begin
          if (byte_valid && byte_out == SYNC_BYTE) begin
            error <= 1'b0;
            state <= REGION;
          end
        end
        ERR: begin
          error <= 1'b1;
          state <= IDLE;
        end
        DONE: ;
        default: begin
          if (frame_err) state <= ERR;
          else if (byte_valid) begin
            case (state)
              REGION: begin
                if (byte_out >= NREG_B) state <= ERR;
                else begin
                  region <= RW'(byte_out);
                  state  <= LEN_LO;
                end
              end
              LEN_LO: state <= LEN_HI;
              LEN_HI: begin
                addr     <= '0;
                byte_idx <= '0;
                if ({1'b0, len_nxt} > DEPTH_L) state <= ERR;
                else if (len_nxt == 16'd0)     state <= CSUM;
                else                           state <= DATA;
              end
              DATA: begin
                if (last_byte) begin
                  byte_idx  <= '0;
                  wr_en     <= 1'b1;
                  wr_region <= region;
                  addr_out  <= addr;
                  data_out  <= word_nxt;
                  if (last_word) state <= CSUM;
                  else addr <= addr + ADDR_W'(1);
                end else byte_idx <= byte_idx + BW'(1);
              end
              CSUM: begin
                if (byte_out == csum_p0) begin
                  region_loaded <= mask_set;
                  if (&mask_set) begin
                    done  <= 1'b1;
                    state <= DONE;
                  end else state <= IDLE;
                end else state <= ERR;
              end
              default: state <= IDLE;
            endcase
          end else if (tmo == TW'(TIMEOUT_CYC - 1)) state <= ERR;
        end
      endcase
    end
  end

  // Payload datapath: length capture, word assembly and running checksum.
  always_ff @(posedge clk) begin
    if (byte_valid) begin
      case (state)
        LEN_LO: len_lo_p0 <= byte_out;
        LEN_HI: begin
          len_p0  <= len_nxt;
          csum_p0 <= 8'h00;
        end
        DATA: begin
          word_p0 <= word_nxt;
          csum_p0 <= csum_p0 ^ byte_out;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: directed UART frames, queued expected writes, forked write monitor.
module tb_uart_boot_loader;
  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        wr_en;
  logic [0:0]  wr_region;
  logic [3:0]  addr_out;
  logic [31:0] data_out;
  logic        busy, done, error;
  logic [1:0]  region_loaded;

  uart_boot_loader #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(32), .ADDR_W(4),
    .NUM_REGIONS(2), .TIMEOUT_CYC(500)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .wr_en(wr_en), .wr_region(wr_region),
    .addr_out(addr_out), .data_out(data_out), .busy(busy),
    .region_loaded(region_loaded), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:0]  r;
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         n_run  = 0;
  int         n_fail = 0;
  logic [7:0] fq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wr_region", 32'(wr_region), 32'(e.r));
          chk("wr_addr",   32'(addr_out),  32'(e.a));
          chk("wr_data",   data_out,       e.d);
        end
      end
    end
  endtask

  task automatic push_wr(input logic [0:0] r, input logic [3:0] a, input logic [31:0] d);
    wr_t e;
    e.r = r; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_fq();
    foreach (fq[i]) send_byte(fq[i], 1'b1);
  endtask

  task automatic chk_status(input string tag, input logic [1:0] rl, input logic err,
                            input logic dn, input logic bsy);
    chk({tag, "_region_loaded"}, 32'(region_loaded), 32'(rl));
    chk({tag, "_error"},         32'(error),         32'(err));
    chk({tag, "_done"},          32'(done),          32'(dn));
    chk({tag, "_busy"},          32'(busy),          32'(bsy));
  endtask

  task automatic chk_q_empty(input string tag);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk_status("rst", 2'b00, 1'b0, 1'b0, 1'b0);

    // Bad checksum: payload XOR is 0x88, 0x01 is sent; both words still land.
    push_wr(1'b0, 4'd0, 32'h44332211);
    push_wr(1'b0, 4'd1, 32'h88776655);
    fq = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h01};
    send_fq();
    chk_status("bad_csum", 2'b00, 1'b1, 1'b0, 1'b0);
    chk_q_empty("bad_csum");

    send_byte(8'hA5, 1'b1);
    chk_status("sync_clears", 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (600) @(negedge clk);
    chk_status("tmo_region", 2'b00, 1'b1, 1'b0, 1'b0);

    fq = {8'hA5, 8'h02};
    send_fq();
    chk_status("bad_region", 2'b00, 1'b1, 1'b0, 1'b0);

    fq = {8'hA5, 8'h00, 8'h11, 8'h00};
    send_fq();
    chk_status("len_too_big", 2'b00, 1'b1, 1'b0, 1'b0);
    chk_q_empty("len_too_big");

    fq = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h11};
    send_fq();
    send_byte(8'h22, 1'b0);
    chk_status("stop_low", 2'b00, 1'b1, 1'b0, 1'b0);

    fq = {8'hA5, 8'h00, 8'h02, 8'h00};
    send_fq();
    chk_status("pre_gap", 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (600) @(negedge clk);
    chk_status("gap_tmo", 2'b00, 1'b1, 1'b0, 1'b0);
    chk_q_empty("gap_tmo");

    // Reset in the middle of the third payload byte.
    fq = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22};
    send_fq();
    rx = 1'b0;
    repeat (35) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_addr", 32'(addr_out), 32'd0);
    chk("mid_rst_data", data_out, 32'd0);
    chk("mid_rst_region", 32'(wr_region), 32'd0);
    chk_status("mid_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);

    push_wr(1'b0, 4'd0, 32'h44332211);
    push_wr(1'b0, 4'd1, 32'h88776655);
    fq = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    send_fq();
    chk_status("load_r0", 2'b01, 1'b0, 1'b0, 1'b0);
    chk_q_empty("load_r0");

    fq = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
    send_fq();
    chk_status("load_r1", 2'b11, 1'b0, 1'b1, 1'b0);

    fq = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_fq();
    chk_status("after_done", 2'b11, 1'b0, 1'b1, 1'b0);
    chk_q_empty("after_done");

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
